// File: rtl/bus_bram_fifo_pkg.sv
// Shared register map, version and reset constants for bus_bram_fifo.
package bus_bram_fifo_pkg;

  localparam logic [2:0] REG_VERSION = 3'd0;
  localparam logic [2:0] REG_THR     = 3'd1;
  localparam logic [2:0] REG_RSVD    = 3'd2;
  localparam logic [2:0] REG_ERR     = 3'd3;
  localparam logic [2:0] REG_FILL    = 3'd4;

  localparam logic [7:0] VERSION     = 8'd2;
  localparam logic [7:0] THR_DEFAULT = 8'd240;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one synchronous read port, no reset.
// Read data appears one cycle after re; never stalls.
module sdp_ram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8192,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdat,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdat;
    if (re) rdat <= mem[raddr];
  end

endmodule

// File: rtl/bus_bram_fifo.sv
// Bus-mapped BRAM FIFO: source words are pushed into RAM, the host pops them through a data window.
// Pop data returns the cycle after BUS_RD; the source is throttled via FIFO_READ_NEXT_OUT when full.
module bus_bram_fifo
  import bus_bram_fifo_pkg::*;
#(
  parameter int unsigned          ABUSWIDTH     = 32,
  parameter logic [ABUSWIDTH-1:0] BASEADDR      = 32'h8000,
  parameter logic [ABUSWIDTH-1:0] HIGHADDR      = 32'h8FFF,
  parameter logic [ABUSWIDTH-1:0] BASEADDR_DATA = 32'h8000_0000,
  parameter logic [ABUSWIDTH-1:0] HIGHADDR_DATA = 32'h9000_0000,
  parameter int unsigned          DEPTH         = 8192
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [31:0]          BUS_DATA,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic                 FIFO_READ_NEXT_OUT,
  input  logic                 FIFO_EMPTY_IN,
  input  logic [31:0]          FIFO_DATA,
  output logic                 FIFO_NOT_EMPTY,
  output logic                 FIFO_FULL,
  output logic                 FIFO_NEAR_FULL,
  output logic                 FIFO_READ_ERROR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SH = AW - 8;

  logic                 ctrl_hit;
  logic                 data_hit;
  logic [ABUSWIDTH-1:0] ctrl_off;
  logic                 ctrl_low;
  logic [2:0]           sel;

  assign ctrl_hit = (BUS_ADD >= BASEADDR) && (BUS_ADD <= HIGHADDR);
  assign data_hit = (BUS_ADD >= BASEADDR_DATA) && (BUS_ADD <= HIGHADDR_DATA);
  assign ctrl_off = BUS_ADD - BASEADDR;
  assign ctrl_low = ctrl_off < ABUSWIDTH'(8);
  assign sel      = ctrl_off[2:0];

  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    err_cnt, err_cnt_nxt;
  logic [7:0]    thr, thr_nxt;
  logic [31:0]   fill_lat, fill_lat_nxt;
  logic [31:0]   fill_now;
  logic [CW-1:0] thr_words_nxt;

  logic ctrl_rd, ctrl_wr, soft_rst, thr_wr;
  logic data_rd, pop_ok, pop_err, push;

  assign ctrl_rd  = BUS_RD && ctrl_hit && ctrl_low;
  assign ctrl_wr  = BUS_WR && ctrl_hit && ctrl_low;
  assign soft_rst = ctrl_wr && (sel == REG_VERSION);
  assign thr_wr   = ctrl_wr && (sel == REG_THR);
  assign data_rd  = BUS_RD && data_hit;
  // A word pushed this cycle is not yet in RAM, so an empty count means an error pop.
  assign pop_ok   = data_rd && (cnt != '0);
  assign pop_err  = data_rd && (cnt == '0);

  assign FIFO_READ_NEXT_OUT = !FIFO_EMPTY_IN && !FIFO_FULL && BUS_RST_N;
  assign push               = FIFO_READ_NEXT_OUT && !soft_rst;

  assign fill_now      = {{(32-CW-2){1'b0}}, cnt, 2'b00};
  assign thr_words_nxt = CW'(thr_nxt) << SH;

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    cnt_nxt      = cnt;
    err_cnt_nxt  = err_cnt;
    thr_nxt      = thr;
    fill_lat_nxt = fill_lat;
    if (push)   wr_ptr_nxt = wr_ptr + 1'b1;
    if (pop_ok) rd_ptr_nxt = rd_ptr + 1'b1;
    case ({push, pop_ok})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
    if (pop_err) err_cnt_nxt = sat_inc8(err_cnt);
    if (ctrl_rd && (sel == REG_FILL)) fill_lat_nxt = fill_now;
    if (thr_wr) thr_nxt = BUS_DATA[7:0];
    // Soft reset keeps the threshold; only the bus reset restores it.
    if (soft_rst) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      cnt_nxt      = '0;
      err_cnt_nxt  = '0;
      fill_lat_nxt = '0;
    end
  end

  logic [7:0] ctrl_byte;

  always_comb begin
    ctrl_byte = 8'h00;
    if (ctrl_low) begin
      case (sel)
        REG_VERSION: ctrl_byte = VERSION;
        REG_THR:     ctrl_byte = thr;
        REG_RSVD:    ctrl_byte = 8'h00;
        REG_ERR:     ctrl_byte = err_cnt;
        REG_FILL:    ctrl_byte = fill_now[7:0];
        3'd5:        ctrl_byte = fill_lat[15:8];
        3'd6:        ctrl_byte = fill_lat[23:16];
        3'd7:        ctrl_byte = fill_lat[31:24];
        default:     ctrl_byte = 8'h00;
      endcase
    end
  end

  logic       rd_q;
  logic       data_q;
  logic       err_q;
  logic [7:0] ctrl_q;

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      err_cnt        <= '0;
      thr            <= THR_DEFAULT;
      fill_lat       <= '0;
      rd_q           <= 1'b0;
      data_q         <= 1'b0;
      err_q          <= 1'b0;
      ctrl_q         <= '0;
      FIFO_NOT_EMPTY <= 1'b0;
      FIFO_FULL      <= 1'b0;
      FIFO_NEAR_FULL <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      cnt            <= cnt_nxt;
      err_cnt        <= err_cnt_nxt;
      thr            <= thr_nxt;
      fill_lat       <= fill_lat_nxt;
      rd_q           <= BUS_RD && (ctrl_hit || data_hit);
      data_q         <= data_rd;
      err_q          <= pop_err;
      ctrl_q         <= ctrl_byte;
      FIFO_NOT_EMPTY <= cnt_nxt != '0;
      FIFO_FULL      <= cnt_nxt == CW'(DEPTH);
      FIFO_NEAR_FULL <= cnt_nxt >= thr_words_nxt;
    end
  end

  // The RAM's registered read port serves as the head register.
  logic [31:0] ram_q;

  sdp_ram #(
    .DW    (32),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK   (BUS_CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdat  (FIFO_DATA),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdat  (ram_q)
  );

  logic [31:0] rd_dat;

  assign rd_dat          = data_q ? (err_q ? 32'h0 : ram_q) : {24'h0, ctrl_q};
  assign BUS_DATA        = rd_q ? rd_dat : {32{1'bz}};
  assign FIFO_READ_ERROR = err_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^BUS_DATA[31:8];

endmodule

// File: tb/tb_bus_bram_fifo.sv
// Randomized and directed bench for bus_bram_fifo against a queue-based reference model.
module tb_bus_bram_fifo;

  localparam int unsigned DEPTH = 8192;
  localparam int          SCALE = DEPTH / 256;
  localparam logic [31:0] CBASE = 32'h8000;
  localparam logic [31:0] CHIGH = 32'h8FFF;
  localparam logic [31:0] DBASE = 32'h8000_0000;
  localparam logic [31:0] DHIGH = 32'h9000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_add;
  wire  [31:0] bus_data;
  logic [31:0] tb_dat;
  logic        tb_drv;
  logic        bus_rd, bus_wr;
  logic        read_next, empty_in;
  logic [31:0] src_dat;
  logic        not_empty, full, near_full, read_err;

  assign bus_data = tb_drv ? tb_dat : {32{1'bz}};
  always #5 clk = ~clk;

  bus_bram_fifo #(.DEPTH(DEPTH)) dut (
    .BUS_CLK            (clk),
    .BUS_RST_N          (rst_n),
    .BUS_ADD            (bus_add),
    .BUS_DATA           (bus_data),
    .BUS_RD             (bus_rd),
    .BUS_WR             (bus_wr),
    .FIFO_READ_NEXT_OUT (read_next),
    .FIFO_EMPTY_IN      (empty_in),
    .FIFO_DATA          (src_dat),
    .FIFO_NOT_EMPTY     (not_empty),
    .FIFO_FULL          (full),
    .FIFO_NEAR_FULL     (near_full),
    .FIFO_READ_ERROR    (read_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the control registers.
  logic [31:0] mq[$];
  int          m_err, m_thr, m_cnt;
  logic [31:0] m_fill, m_off, exp_dat;
  bit          exp_vld, exp_rerr, m_chit, m_dhit, m_push, m_soft;
  bit          model_live = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_err = 0; m_thr = 240; m_fill = 0;
        exp_vld = 0; exp_rerr = 0; exp_dat = 0;
      end else begin
        m_cnt  = mq.size();
        m_chit = (bus_add >= CBASE) && (bus_add <= CHIGH);
        m_dhit = (bus_add >= DBASE) && (bus_add <= DHIGH);
        m_off  = bus_add - CBASE;
        m_push = !empty_in && (m_cnt < DEPTH);
        m_soft = bus_wr && m_chit && (m_off == 0);
        exp_vld = bus_rd && (m_chit || m_dhit);
        exp_rerr = 0;
        exp_dat = 0;
        if (bus_rd && m_dhit) begin
          if (m_cnt == 0) begin
            exp_rerr = 1;
            if (m_err < 255) m_err++;
          end else begin
            exp_dat = mq.pop_front();
          end
        end else if (bus_rd && m_chit) begin
          case (m_off)
            0: exp_dat = 2;
            1: exp_dat = m_thr;
            3: exp_dat = m_err;
            4: begin m_fill = m_cnt * 4; exp_dat = m_fill & 32'hFF; end
            5: exp_dat = (m_fill >> 8) & 32'hFF;
            6: exp_dat = (m_fill >> 16) & 32'hFF;
            7: exp_dat = (m_fill >> 24) & 32'hFF;
            default: exp_dat = 0;
          endcase
        end
        if (bus_wr && m_chit && (m_off == 1)) m_thr = int'(tb_dat[7:0]);
        if (m_push && !m_soft) mq.push_back(src_dat);
        if (m_soft) begin
          mq.delete();
          m_err = 0;
          m_fill = 0;
        end
      end
      model_live = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("not_empty", not_empty, mq.size() != 0);
        chk("full", full, mq.size() == DEPTH);
        chk("near_full", near_full, mq.size() >= m_thr * SCALE);
        chk("read_next", read_next, rst_n && !empty_in && (mq.size() < DEPTH));
        chk("read_error", read_err, exp_rerr);
        if (exp_vld) chk("bus_data", bus_data, exp_dat);
      end
    end
  end

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    bus_add = a;
    bus_rd = 1'b1;
    @(posedge clk); #1;
    bus_rd = 1'b0;
    @(negedge clk);
    d = bus_data;
    e = read_err;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] v);
    bus_add = a;
    tb_dat = {24'h0, v};
    tb_drv = 1'b1;
    bus_wr = 1'b1;
    @(posedge clk); #1;
    bus_wr = 1'b0;
    tb_drv = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          pushes, nf_at, extra, words, cyc;
    bit          prev_rd, saw_full;

    rst_n = 0; bus_add = 0; tb_dat = 0; tb_drv = 0;
    bus_rd = 0; bus_wr = 0; empty_in = 1; src_dat = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state and register map.
    chk("rst_not_empty", not_empty, 0);
    chk("rst_full", full, 0);
    chk("rst_near_full", near_full, 0);
    bus_read(CBASE + 0, d, e); chk("version", d, 32'h2);
    bus_read(CBASE + 3, d, e); chk("rst_err_cnt", d, 32'h0);
    for (int i = 4; i < 8; i++) begin
      bus_read(CBASE + i, d, e); chk("rst_fill", d, 32'h0);
    end

    // Ten source words, fill level, then ordered drain.
    for (int i = 0; i < 10; i++) begin
      empty_in = 0;
      src_dat = 32'hA000_0000 + i;
      @(posedge clk); #1;
    end
    empty_in = 1;
    bus_read(CBASE + 4, d, e); chk("fill_b0", d, 32'h28);
    bus_read(CBASE + 5, d, e); chk("fill_b1", d, 32'h0);
    bus_read(CBASE + 6, d, e); chk("fill_b2", d, 32'h0);
    bus_read(CBASE + 7, d, e); chk("fill_b3", d, 32'h0);
    for (int i = 0; i < 10; i++) begin
      bus_read(DBASE + 32'h40, d, e);
      chk("pop_word", d, 32'hA000_0000 + i);
      chk("pop_no_err", e, 0);
    end
    chk("drained_not_empty", not_empty, 0);

    // Empty reads and error counter saturation.
    bus_read(DBASE, d, e);
    chk("empty_read_data", d, 32'h0);
    chk("empty_read_err", e, 1);
    bus_read(CBASE + 3, d, e); chk("err_cnt_1", d, 32'h1);
    for (int i = 0; i < 300; i++) bus_read(DHIGH, d, e);
    bus_read(CBASE + 3, d, e); chk("err_cnt_sat", d, 32'hFF);

    // Continuous source until full.
    empty_in = 0; pushes = 0; nf_at = -1; cyc = 0;
    while (cyc < 10000) begin
      src_dat = $urandom;
      @(negedge clk);
      if (near_full && nf_at < 0) nf_at = pushes;
      if (!read_next) break;
      pushes++;
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    chk("fill_pushes", pushes, DEPTH);
    chk("near_full_at", nf_at, 7680);
    chk("full_flag", full, 1);
    chk("full_read_next", read_next, 0);

    // One pop frees exactly one slot.
    extra = 0;
    bus_add = DBASE;
    bus_rd = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (read_next) extra++;
      @(posedge clk); #1;
      bus_rd = 0;
    end
    chk("one_slot_push", extra, 1);
    empty_in = 1;

    // Back-to-back drain of the full FIFO.
    cyc = 0;
    while (mq.size() != 0 && cyc < 20000) begin
      bus_rd = 1;
      @(posedge clk); #1;
      cyc++;
    end
    bus_rd = 0;
    @(posedge clk); #1;
    chk("full_drain_empty", not_empty, 0);

    // Pointer wrap: 3*DEPTH random pushes interleaved with pops.
    pushes = 0; words = 0; cyc = 0; prev_rd = 0; saw_full = 0;
    while ((pushes < 3 * DEPTH || mq.size() != 0) && cyc < 70000) begin
      empty_in = (pushes >= 3 * DEPTH) || ($urandom_range(0, 9) < 3);
      src_dat = $urandom;
      bus_add = DBASE + {$urandom_range(0, 255), 2'b00};
      bus_rd = (mq.size() != 0) && ($urandom_range(0, 9) < 8);
      @(negedge clk);
      if (read_next) pushes++;
      if (full) saw_full = 1;
      if (prev_rd && !read_err) words++;
      prev_rd = bus_rd;
      @(posedge clk); #1;
      cyc++;
    end
    bus_rd = 0;
    empty_in = 1;
    @(negedge clk);
    if (prev_rd && !read_err) words++;
    @(posedge clk); #1;
    chk("wrap_push_total", pushes >= 3 * DEPTH, 1);
    chk("wrap_words_returned", words, pushes);
    chk("wrap_never_full", saw_full, 0);

    // Soft reset keeps the threshold and drops a coincident push.
    bus_write(CBASE + 1, 8'd37);
    bus_write(CBASE + 2, 8'h55);
    for (int i = 0; i < 5; i++) begin
      empty_in = 0;
      src_dat = $urandom;
      @(posedge clk); #1;
    end
    bus_read(CBASE + 4, d, e); chk("pre_soft_fill", d, 32'h14);
    empty_in = 0;
    bus_write(CBASE + 0, 8'hAA);
    empty_in = 1;
    chk("soft_not_empty", not_empty, 0);
    bus_read(CBASE + 4, d, e); chk("soft_fill", d, 32'h0);
    bus_read(CBASE + 3, d, e); chk("soft_err_cnt", d, 32'h0);
    bus_read(CBASE + 1, d, e); chk("soft_thr_kept", d, 32'd37);
    bus_read(CBASE + 2, d, e); chk("reserved_reads_0", d, 32'h0);
    bus_read(CBASE + 8, d, e); chk("offset8_reads_0", d, 32'h0);

    // Bus reset restores the threshold.
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    bus_read(CBASE + 1, d, e); chk("rst_thr", d, 32'hF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
